bus_share_arbiter: RTL and testbench
====================================

# bus_share_arbiter

Round-robin arbiter that shares one DATA_W-bit output bus between two requesters, replacing the static 2:1 bus select with a handshaked, fair scheduler. Each requester offers a valid/data/ready stream. The block chooses a winner, muxes its data into a registered output slot and holds ownership for up to BURST_MAX consecutive transfers while the other side waits. It sits between two producer datapaths and a single shared downstream consumer.

## Interface
- DATA_W, 4, width of each requester's data bus and of out_data
- BURST_MAX, 4, maximum consecutive transfers by one owner while the other requester is valid; legal range 1..15
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_0_valid  input  1  requester 0 offers data
- req_0_data  input  DATA_W  requester 0 payload
- req_0_ready  output  1  requester 0 payload accepted this cycle
- req_1_valid  input  1  requester 1 offers data
- req_1_data  input  DATA_W  requester 1 payload
- req_1_ready  output  1  requester 1 payload accepted this cycle
- out_valid  output  1  output slot holds data
- out_data  output  DATA_W  output payload (registered)
- out_src  output  1  index of the requester that supplied out_data (registered)
- out_ready  input  1  consumer accepts the output slot this cycle

## Operation
- Reset values: out_valid=0, out_data=0, out_src=0, state=IDLE, burst_cnt=0, last_grant=1 (requester 0 wins first contention).
- load_en = ~out_valid | out_ready. Arbitration only takes effect when load_en=1. Otherwise all state holds.
- States: IDLE (no owner), OWN0, OWN1.
- Winner selection (combinational, evaluated when load_en=1):
  - IDLE: both valid → requester ~last_grant. One valid → that one. None → no winner.
  - OWNx: req_x_valid and (other not valid or burst_cnt < BURST_MAX) → x. Else other valid → other. Else no winner.
- req_k_ready = load_en & winner exists & winner==k. It is never asserted for a requester whose valid is low.
- On transfer (winner exists, load_en=1):
  - out_data ← winner data, out_src ← winner, out_valid ← 1, last_grant ← winner.
  - State ← OWN(winner).
  - If winner equals the current owner, burst_cnt ← min(burst_cnt+1, BURST_MAX). Otherwise burst_cnt ← 1.
- load_en=1 with no winner: out_valid ← 0 only if out_ready drained the slot. State ← IDLE, burst_cnt ← 0. last_grant is kept.
- Burst limit: burst_cnt only forces a switch when the other requester is valid. A lone requester streams indefinitely, with burst_cnt saturated at BURST_MAX.
- Data width: pure pass-through, no arithmetic on payload. burst_cnt is 4 bits.
- Reset mid-operation: the asynchronous assertion immediately returns every output and all internal state to the reset values. Any slot content is lost.

## Timing
- Latency: a requester transfer in cycle N (valid & ready) appears on out_data/out_valid in cycle N+1.
- Throughput: one transfer per cycle while out_ready=1 continuously.
- Backpressure: when out_valid=1 and out_ready=0, both readys are 0. out_data and out_src are stable until accepted.
- Simultaneous drain and load: the slot is refilled in the same cycle out_ready consumes it, with no bubble.
- Requester valid may drop at any time without a transfer. The grant is never latched ahead of the load.
- The readys depend combinationally on the valids and on out_ready. There is no combinational path from any data input to any output.

## Test plan
- Single stream: req_0 sends 0x1,0x2,0x3 with out_ready=1 and req_1 idle → out_data 0x1,0x2,0x3 on consecutive cycles, each one cycle after acceptance, out_src=0, req_1_ready=0 throughout.
- First contention after reset: both valid in cycle 1 with data 0xA/0x5 held, BURST_MAX=4 → req_0 wins 4 transfers (0xA×4), then req_1 wins 4 (0x5×4), alternating. out_src toggles every 4 outputs.
- Owner drops: in OWN0 with burst_cnt=2, req_0_valid falls while req_1 is valid → the next load grants req_1 and burst_cnt=1.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 with out_data=0x7 → out_data stays 0x7, both readys are 0, and state and burst_cnt are unchanged. Release → 0x7 is consumed and the next winner is loaded in the same cycle.
- Idle and round-robin memory: req_1 wins last, all valids go low (state IDLE, out_valid drains to 0), then both assert → req_0 wins.
- Async reset mid-burst: rst_n is pulsed low between clock edges during OWN1 → out_valid=0, out_data=0 and out_src=0 immediately. After release, contention grants req_0 first.

Source files
------------

// File: rtl/bus_share_arbiter.sv
// Two-requester round-robin bus arbiter with burst ownership and a registered output slot.
// Ownership sticks for up to BURST_MAX transfers while the other requester is waiting.
module bus_share_arbiter #(
    parameter int DATA_W    = 4,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_0_valid,
    input  logic [DATA_W-1:0] req_0_data,
    output logic              req_0_ready,
    input  logic              req_1_valid,
    input  logic [DATA_W-1:0] req_1_data,
    output logic              req_1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready
);
    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state, state_nxt;
    logic [3:0] burst_cnt, burst_nxt;
    logic       last_grant;
    logic       load_en, win_vld, win;
    logic       own, mine_vld, other_vld;

    always_comb begin
        load_en   = ~out_valid | out_ready;
        win_vld   = 1'b0;
        win       = 1'b0;
        own       = (state == OWN1);
        mine_vld  = own ? req_1_valid : req_0_valid;
        other_vld = own ? req_0_valid : req_1_valid;
        state_nxt = state;
        burst_nxt = burst_cnt;

        case (state)
            IDLE: begin
                if (req_0_valid & req_1_valid) begin
                    win_vld = 1'b1;
                    win     = ~last_grant;
                end else if (req_0_valid | req_1_valid) begin
                    win_vld = 1'b1;
                    win     = req_1_valid;
                end
            end
            OWN0, OWN1: begin
                // The burst limit only bites when the other side is actually waiting.
                if (mine_vld && (!other_vld || burst_cnt < BMAX)) begin
                    win_vld = 1'b1;
                    win     = own;
                end else if (other_vld) begin
                    win_vld = 1'b1;
                    win     = ~own;
                end
            end
            default: ;
        endcase

        if (!load_en) win_vld = 1'b0;

        req_0_ready = win_vld & ~win;
        req_1_ready = win_vld & win;

        if (load_en) begin
            if (win_vld) begin
                state_nxt = win ? OWN1 : OWN0;
                if (state != IDLE && win == own)
                    burst_nxt = (burst_cnt >= BMAX) ? BMAX : burst_cnt + 4'd1;
                else
                    burst_nxt = 4'd1;
            end else begin
                state_nxt = IDLE;
                burst_nxt = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // Output slot: refilled in the same cycle it drains, so no bubble under streaming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= 1'b0;
            last_grant <= 1'b1;
        end else if (load_en) begin
            if (win_vld) begin
                out_valid  <= 1'b1;
                out_data   <= win ? req_1_data : req_0_data;
                out_src    <= win;
                last_grant <= win;
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bus_share_arbiter.sv
// Randomized bench for bus_share_arbiter against an integer-level reference model.
module tb_bus_share_arbiter;
    localparam int DATA_W    = 4;
    localparam int BURST_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_0_valid, req_1_valid;
    logic [DATA_W-1:0] req_0_data, req_1_data;
    logic              req_0_ready, req_1_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic              out_ready;

    int errors = 0;
    int checks = 0;

    // Reference model: owner -1 means nobody owns the bus.
    int   m_owner, m_cnt, m_last;
    bit   m_vld, m_src;
    logic [DATA_W-1:0] m_data;

    bus_share_arbiter #(.DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_0_valid(req_0_valid), .req_0_data(req_0_data), .req_0_ready(req_0_ready),
        .req_1_valid(req_1_valid), .req_1_data(req_1_data), .req_1_ready(req_1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_owner = -1; m_cnt = 0; m_last = 1;
        m_vld = 0; m_src = 0; m_data = '0;
    endtask

    function automatic int m_pick();
        bit v0 = req_0_valid, v1 = req_1_valid, mine, oth;
        if (m_vld && !out_ready) return -1;
        if (m_owner < 0) begin
            if (v0 && v1) return 1 - m_last;
            if (v0) return 0;
            if (v1) return 1;
            return -1;
        end
        mine = (m_owner == 1) ? v1 : v0;
        oth  = (m_owner == 1) ? v0 : v1;
        if (mine && (!oth || m_cnt < BURST_MAX)) return m_owner;
        if (oth) return 1 - m_owner;
        return -1;
    endfunction

    task automatic m_update(input int w);
        if (m_vld && !out_ready) return;
        if (w < 0) begin
            m_vld = 0; m_owner = -1; m_cnt = 0;
        end else begin
            m_data = (w == 1) ? req_1_data : req_0_data;
            m_src  = (w == 1);
            m_vld  = 1;
            m_cnt  = (w == m_owner) ? ((m_cnt + 1 > BURST_MAX) ? BURST_MAX : m_cnt + 1) : 1;
            m_owner = w;
            m_last  = w;
        end
    endtask

    // One clock: check registered outputs, apply inputs, check readys, then advance model.
    task automatic step(input bit v0, input logic [DATA_W-1:0] d0,
                        input bit v1, input logic [DATA_W-1:0] d1, input bit ordy);
        int w;
        @(negedge clk);
        chk("out_valid", out_valid, m_vld);
        chk("out_data", out_data, m_data);
        chk("out_src", out_src, m_src);
        req_0_valid = v0; req_0_data = d0;
        req_1_valid = v1; req_1_data = d1;
        out_ready   = ordy;
        #1;
        w = m_pick();
        chk("req_0_ready", req_0_ready, (w == 0));
        chk("req_1_ready", req_1_ready, (w == 1));
        @(posedge clk);
        m_update(w);
    endtask

    // Held contention from IDLE: req_0 gets the first burst, then they alternate every BURST_MAX.
    task automatic contention();
        for (int i = 0; i < 3 * BURST_MAX; i++) begin
            step(1'b1, 4'hA, 1'b1, 4'h5, 1'b1);
            #1;
            chk("rr_src", out_src, ((i / BURST_MAX) % 2));
            chk("rr_data", out_data, (((i / BURST_MAX) % 2) != 0) ? 4'h5 : 4'hA);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_0_valid = 0; req_1_valid = 0; req_0_data = '0; req_1_data = '0; out_ready = 0;
        m_reset();
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 4'h0);
        chk("rst_out_src", out_src, 1'b0);
        rst_n = 1'b1;

        contention();

        // Drain, then single stream from req_0 only.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        for (int i = 1; i <= 3; i++) step(1, 4'(i), 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Randomized segments with different traffic shapes.
        for (int seg = 0; seg < 16; seg++) begin
            int mode = seg % 4;
            for (int c = 0; c < 40; c++) begin
                bit v0, v1, ordy;
                v0   = ($urandom_range(0, 99) < ((mode == 2) ? 90 : 65));
                v1   = (mode == 2) ? 1'b0 : ($urandom_range(0, 99) < 65);
                ordy = ($urandom_range(0, 99) < ((mode == 3) ? 30 : (mode == 1 ? 100 : 75)));
                if (mode == 1) begin v0 = 1; v1 = 1; end
                step(v0, 4'($urandom), v1, 4'($urandom), ordy);
            end
        end

        // Get into OWN1 with data in the slot, then pulse reset between edges.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 4'h9, 1);
        step(0, 0, 1, 4'hC, 1);
        @(negedge clk);
        chk("pre_rst_src", out_src, 1'b1);
        req_0_valid = 0; req_1_valid = 0; out_ready = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_out_data", out_data, 4'h0);
        chk("async_out_src", out_src, 1'b0);
        rst_n = 1'b1;
        m_reset();

        contention();
        step(0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
